// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver, LSB first, 16x oversampled. Returns each well-framed byte
// with a one-cycle valid strobe; a low stop bit gives frame_err and parks in BREAK.
module uart_rx_frame #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CLKS_PER_TICK = CLK_HZ / (BAUD * 16);
  localparam int unsigned TW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;

  generate
    if (CLKS_PER_TICK < 1) begin : g_bad_rate
      $error("uart_rx_frame: CLK_HZ / (BAUD*16) must be at least 1");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t        state, state_nx;
  logic          rx_m, rx_s;
  logic [TW-1:0] div;
  logic          tick;
  logic [3:0]    tcnt, tcnt_nx;
  logic [2:0]    bcnt, bcnt_nx;
  logic [7:0]    shreg, shreg_nx;
  logic [7:0]    data_nx;
  logic          valid_nx, ferr_nx;

  assign tick = (div == TW'(CLKS_PER_TICK - 1));

  always_comb begin
    state_nx = state;
    tcnt_nx  = tcnt;
    bcnt_nx  = bcnt;
    shreg_nx = shreg;
    data_nx  = data;
    valid_nx = 1'b0;
    ferr_nx  = 1'b0;
    case (state)
      IDLE: begin
        tcnt_nx = '0;
        if (!rx_s) state_nx = START;
      end
      START: begin
        if (tick) begin
          tcnt_nx = tcnt + 4'd1;
          if (tcnt == 4'd7) begin
            tcnt_nx  = '0;
            bcnt_nx  = '0;
            state_nx = rx_s ? IDLE : DATA;
          end
        end
      end
      DATA: begin
        // tcnt wraps 15 -> 0, so each sample lands exactly 16 ticks after the last
        if (tick) begin
          tcnt_nx = tcnt + 4'd1;
          if (tcnt == 4'd15) begin
            shreg_nx = {rx_s, shreg[7:1]};
            bcnt_nx  = bcnt + 3'd1;
            if (bcnt == 3'd7) state_nx = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          tcnt_nx = tcnt + 4'd1;
          if (tcnt == 4'd15) begin
            if (rx_s) begin
              data_nx  = shreg;
              valid_nx = 1'b1;
              state_nx = IDLE;
            end else begin
              ferr_nx  = 1'b1;
              state_nx = BRK;
            end
          end
        end
      end
      BRK: begin
        if (rx_s) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      div       <= '0;
      tcnt      <= '0;
      bcnt      <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      state     <= state_nx;
      tcnt      <= tcnt_nx;
      bcnt      <= bcnt_nx;
      shreg     <= shreg_nx;
      data      <= data_nx;
      valid     <= valid_nx;
      frame_err <= ferr_nx;
      busy      <= (state_nx != IDLE);
      // Holding the divider at 0 through IDLE phase-aligns ticks to the start edge
      if (state == IDLE || tick) div <= '0;
      else                       div <= div + TW'(1);
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame at T=1 (16 clocks per bit): directed
// frame scenarios followed by random bytes with random gaps and baud skew.
module tb_uart_rx_frame;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  int unsigned cyc = 0;
  int unsigned vcount = 0;
  int unsigned fcount = 0;
  int unsigned both = 0;
  logic [7:0]  got_q[$];
  int unsigned vtime_q[$];
  logic [7:0]  exp_q[$];

  localparam real BIT = 160.0;

  uart_rx_frame #(.CLK_HZ(1_600_000), .BAUD(100_000)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .data(data), .valid(valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid) begin
      vcount++;
      got_q.push_back(data);
      vtime_q.push_back(cyc);
    end
    if (frame_err) fcount++;
    if (valid && frame_err) both++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input real bit_t);
    rx = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_t);
    end
    rx = stop;
    #(bit_t);
  endtask

  task automatic wait_valid(input int unsigned target, input string tag);
    int unsigned n = 0;
    while (vcount < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(vcount >= target), 32'd1);
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned base, fbase, n, lowcnt, seen, seen_busy;
    logic [7:0] b;

    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_data", 32'(data), 32'h00);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_ferr", 32'(frame_err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    // Single byte with busy timing
    align();
    fork
      send_byte(8'h41, 1'b1, BIT);
      begin
        repeat (3) @(negedge clk);
        check("busy_before_rise", 32'(busy), 32'd0);
        @(negedge clk);
        check("busy_rise_3clk", 32'(busy), 32'd1);
        n = 4; lowcnt = 0; seen = 0;
        while (seen == 0 && n < 400) begin
          @(negedge clk);
          n++;
          if (valid) seen = 1;
          else if (!busy) lowcnt++;
        end
        check("single_valid_seen", seen, 32'd1);
        check("single_busy_held", lowcnt, 32'd0);
        check("single_busy_falls_with_valid", 32'(busy), 32'd0);
        check("single_latency_window", 32'(n >= 150 && n <= 160), 32'd1);
      end
    join
    check("single_data", 32'(data), 32'h41);
    check("single_one_valid", vcount, 32'd1);
    check("single_no_ferr", fcount, 32'd0);

    // Back-to-back
    align();
    base = vcount;
    send_byte(8'h55, 1'b1, BIT);
    send_byte(8'hA3, 1'b1, BIT);
    wait_valid(base + 2, "b2b_two_valid");
    if (vcount >= base + 2) begin
      check("b2b_first", 32'(got_q[base]), 32'h55);
      check("b2b_second", 32'(got_q[base+1]), 32'hA3);
      check("b2b_spacing", vtime_q[base+1] - vtime_q[base], 32'd160);
    end
    check("b2b_no_ferr", fcount, 32'd0);

    // Glitch
    align();
    base = vcount;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    seen_busy = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) seen_busy = 1;
    end
    check("glitch_busy_pulsed", seen_busy, 32'd1);
    check("glitch_back_idle", 32'(busy), 32'd0);
    check("glitch_no_valid", vcount, base);
    check("glitch_no_ferr", fcount, 32'd0);

    // Framing error then recovery
    align();
    base = vcount;
    send_byte(8'h7E, 1'b0, BIT);
    repeat (24) @(posedge clk);
    #1;
    check("ferr_one_pulse", fcount, 32'd1);
    check("ferr_break_holds_busy", 32'(busy), 32'd1);
    check("ferr_data_kept", 32'(data), 32'hA3);
    check("ferr_no_valid", vcount, base);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    check("ferr_idle_after_high", 32'(busy), 32'd0);
    align();
    send_byte(8'h12, 1'b1, BIT);
    wait_valid(base + 1, "ferr_next_valid");
    check("ferr_next_data", 32'(data), 32'h12);
    check("ferr_still_one", fcount, 32'd1);

    // Reset during data bit 4
    align();
    base = vcount;
    b = 8'hC5;
    rx = 1'b0;
    #(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      #(BIT);
    end
    rx = b[4];
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    rx = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(data), 32'h00);
    check("rst_valid", 32'(valid), 32'd0);
    repeat (200) @(negedge clk);
    check("rst_no_strobe", vcount, base);
    check("rst_no_ferr", fcount, 32'd1);
    align();
    send_byte(8'h33, 1'b1, BIT);
    wait_valid(base + 1, "rst_next_valid");
    check("rst_next_data", 32'(data), 32'h33);

    // Random bytes, random idle gaps, baud skew within +/-2.5 %
    align();
    base = vcount;
    fbase = fcount;
    for (int k = 0; k < 20; k++) begin
      int sk;
      real bt;
      b  = 8'($urandom);
      sk = int'($urandom_range(0, 50)) - 25;
      bt = BIT * (1000.0 + real'(sk)) / 1000.0;
      exp_q.push_back(b);
      #(real'($urandom_range(0, 20)) * 10.0);
      send_byte(b, 1'b1, bt);
    end
    wait_valid(base + 20, "rand_all_received");
    repeat (40) @(negedge clk);
    check("rand_count", vcount - base, 32'd20);
    for (int i = 0; i < 20; i++) begin
      if (base + i < got_q.size())
        check($sformatf("rand_byte_%0d", i), 32'(got_q[base+i]), 32'(exp_q[i]));
    end
    check("rand_no_ferr", fcount, fbase);
    check("never_both_strobes", both, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL global_timeout: observed timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
